// File: rtl/base_lane_pack.sv
// base_lane_pack: packs partially filled input beats (0..ways valid lanes)
// into dense output words of `ways` lanes, with packet-end flush.
// Optional macro BASE_LANE_PACK_CNT_CHK_EN: flag and drop beats whose lane
// count exceeds `ways` (sticky o_err). Without it, o_err is tied low and
// oversized counts are clamped to `ways`.

// One output lane of the rotator plus the hold/input merge for that lane.
module base_lane_pack_lane #(
  parameter int width     = 1,
  parameter int ways      = 1,
  parameter int cnt_width = 1,
  parameter int lane      = 0
) (
  input  logic [ways*width-1:0] d_in,
  input  logic [cnt_width-1:0]  ptr,
  input  logic [width-1:0]      hold_lane,
  output logic [width-1:0]      rot_lane,
  output logic [width-1:0]      merged_lane
);
  // input lane k lands on packed position (ptr+k) mod ways
  always_comb begin
    rot_lane = '0;
    for (int k = 0; k < ways; k++)
      if (((k + int'(ptr)) % ways) == lane) rot_lane = d_in[k*width +: width];
  end

  // lanes below ptr are already filled from earlier beats
  assign merged_lane = (lane < int'(ptr)) ? hold_lane : rot_lane;
endmodule

module base_lane_pack #(
  parameter int width     = 1,
  parameter int ways      = 1,
  parameter int cnt_width = $clog2(ways+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [ways*width-1:0]  i_d,
  input  logic [cnt_width-1:0]   i_cnt,
  input  logic                   i_end,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [ways*width-1:0]  o_d,
  output logic [cnt_width-1:0]   o_cnt,
  output logic                   o_last,
  output logic                   o_err
);
  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [cnt_width:0] WAYS_S = (cnt_width+1)'(ways);

  logic [ways-1:0][width-1:0] hold_q, hold_n, rot, merged, ld_word, od_q;
  logic [cnt_width-1:0]       ptr_q, ptr_n, eff_cnt, ld_cnt;
  logic [cnt_width:0]         s, rem;
  state_t                     state_q, state_n;
  logic                       out_free, acc, load, ld_last;

  assign out_free = !o_v || o_r;
  assign i_r      = (state_q == RUN) && out_free;
  assign acc      = i_v && i_r;
  assign o_d      = od_q;

  for (genvar j = 0; j < ways; j++) begin : g_lane
    base_lane_pack_lane #(
      .width(width), .ways(ways), .cnt_width(cnt_width), .lane(j)
    ) u_lane (
      .d_in       (i_d),
      .ptr        (ptr_q),
      .hold_lane  (hold_q[j]),
      .rot_lane   (rot[j]),
      .merged_lane(merged[j])
    );
  end

`ifdef BASE_LANE_PACK_CNT_CHK_EN
  logic cnt_bad, err_q;
  assign cnt_bad = ({1'b0, i_cnt} > WAYS_S);
  // illegal beats write no lanes but still honour i_end
  assign eff_cnt = cnt_bad ? '0 : i_cnt;
  assign o_err   = err_q;

  // sticky illegal-count flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (acc && cnt_bad) err_q <= 1'b1;
`else
  // clamp keeps ptr within range so the FSM stays legal
  assign eff_cnt = ({1'b0, i_cnt} > WAYS_S) ? WAYS_S[cnt_width-1:0] : i_cnt;
  assign o_err   = 1'b0;
`endif

  // next-state: merge beat into hold, decide what (if anything) to emit
  always_comb begin
    s       = {1'b0, ptr_q} + {1'b0, eff_cnt};
    rem     = s - WAYS_S;
    hold_n  = hold_q;
    ptr_n   = ptr_q;
    state_n = state_q;
    load    = 1'b0;
    ld_word = '0;
    ld_cnt  = '0;
    ld_last = 1'b0;
    if (state_q == FLUSH) begin
      // hold lanes >= ptr are kept zero, so hold is already a clean word
      if (out_free) begin
        load    = 1'b1;
        ld_word = hold_q;
        ld_cnt  = ptr_q;
        ld_last = 1'b1;
        hold_n  = '0;
        ptr_n   = '0;
        state_n = RUN;
      end
    end else if (acc) begin
      if (s < WAYS_S) begin
        for (int j = 0; j < ways; j++)
          ld_word[j] = (j < int'(s)) ? merged[j] : '0;
        if (i_end) begin
          load    = 1'b1;
          ld_cnt  = s[cnt_width-1:0];
          ld_last = 1'b1;
          hold_n  = '0;
          ptr_n   = '0;
        end else begin
          hold_n = ld_word;
          ptr_n  = s[cnt_width-1:0];
        end
      end else begin
        load    = 1'b1;
        ld_word = merged;
        ld_cnt  = WAYS_S[cnt_width-1:0];
        // rotated lanes below ptr are the overflow, already at positions 0..
        for (int j = 0; j < ways; j++)
          hold_n[j] = (j < int'(rem)) ? rot[j] : '0;
        ptr_n = rem[cnt_width-1:0];
        if (i_end) begin
          if (rem == '0) ld_last = 1'b1;
          else           state_n = FLUSH;
        end
      end
    end
  end

  // state and output register; reload on the drain cycle avoids bubbles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q   <= '0;
      hold_q  <= '0;
      o_v     <= 1'b0;
      od_q    <= '0;
      o_cnt   <= '0;
      o_last  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
      if (load) begin
        o_v    <= 1'b1;
        od_q   <= ld_word;
        o_cnt  <= ld_cnt;
        o_last <= ld_last;
      end else if (o_r) begin
        o_v <= 1'b0;
      end
    end
endmodule

// File: tb/tb_base_lane_pack.sv
// Bench for base_lane_pack (width=8, ways=4): directed packets with literal
// expectations plus randomized traffic, all checked against a lane-queue model.
module tb_base_lane_pack;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_v, i_r, i_end, o_v, o_r, o_last, o_err;
  logic [31:0] i_d, o_d;
  logic [2:0]  i_cnt, o_cnt;

  base_lane_pack #(.width(8), .ways(4), .cnt_width(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_cnt(i_cnt),
    .i_end(i_end), .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_cnt(o_cnt),
    .o_last(o_last), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; int cnt; logic last; } word_t;

  word_t       exp_q[$];
  logic [7:0]  pend[$];
  logic        exp_err;
  logic [31:0] got_d[$];
  int          got_cnt[$];
  logic        got_last[$];
  int          total = 0, bad = 0;
  logic        acc_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // model: pending lanes form a plain byte queue; words are cut from its head
  task automatic emit(input int n, input logic l);
    word_t w;
    w.d = '0;
    for (int k = 0; k < n; k++) w.d[k*8 +: 8] = pend.pop_front();
    w.cnt  = n;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic model_accept(input logic [31:0] d, input int c, input logic e);
    int n = c;
`ifdef BASE_LANE_PACK_CNT_CHK_EN
    if (c > 4) begin exp_err = 1'b1; n = 0; end
`endif
    for (int k = 0; k < n; k++) pend.push_back(d[k*8 +: 8]);
    if (!e) begin
      while (pend.size() >= 4) emit(4, 1'b0);
    end else begin
      while (pend.size() > 4) emit(4, 1'b0);
      emit(pend.size(), 1'b1);
    end
  endtask

  task automatic compare_outputs();
    chk("o_v", o_v, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("o_d", o_d, exp_q[0].d);
      chk("o_cnt", o_cnt, exp_q[0].cnt);
      chk("o_last", o_last, exp_q[0].last);
    end
    // one word presented and none owed: ready follows o_r; a word owed: stalled
    chk("i_r", i_r, (exp_q.size() == 0) || (exp_q.size() == 1 && o_r));
    chk("o_err", o_err, exp_err);
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic [2:0] c,
                       input logic e, input logic r);
    @(negedge clk);
    compare_outputs();
    #1;
    i_v = v; i_d = d; i_cnt = c; i_end = e; o_r = r;
    #1;
    acc_f = i_v && i_r;
    if (o_v && o_r) begin
      got_d.push_back(o_d);
      got_cnt.push_back(int'(o_cnt));
      got_last.push_back(o_last);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (acc_f) model_accept(d, int'(c), e);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] c, input logic e);
    int n = 0;
    do begin
      cycle(1'b1, d, c, e, 1'b1);
      n++;
    end while (!acc_f && n < 20);
    if (!acc_f) begin
      total++; bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic clear_got();
    got_d.delete(); got_cnt.delete(); got_last.delete();
  endtask

  task automatic chk_word(input string nm, input int idx, input logic [31:0] d,
                          input int c, input logic l);
    if (got_d.size() > idx) begin
      chk({nm, "_d"}, got_d[idx], d);
      chk({nm, "_cnt"}, got_cnt[idx], c);
      chk({nm, "_last"}, got_last[idx], l);
    end else begin
      total++; bad++;
      $display("FAIL %s_missing actual=%0d words required=%0d", nm, got_d.size(), idx + 1);
    end
  endtask

  // asynchronous reset mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    compare_outputs();
    #1;
    rst_n = 1'b0; i_v = 1'b0;
    #1;
    chk("rst_o_v", o_v, 1'b0);
    chk("rst_o_d", o_d, 32'h0);
    chk("rst_o_cnt", o_cnt, 3'd0);
    chk("rst_o_last", o_last, 1'b0);
    chk("rst_o_err", o_err, 1'b0);
    exp_q.delete(); pend.delete(); exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_got();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; i_v = 1'b0; i_d = '0; i_cnt = '0; i_end = 1'b0; o_r = 1'b1;
    exp_err = 1'b0;
    do_reset();
    idle(1);
    chk("rst_i_r", i_r, 1'b1);

    // two 3-lane beats straddle a word, then an empty end beat flushes
    clear_got();
    send(32'h00ACABAA, 3'd3, 1'b0);
    send(32'h00BCBBBA, 3'd3, 1'b0);
    send(32'h00000000, 3'd0, 1'b1);
    idle(3);
    chk("t1_n", got_d.size(), 2);
    chk_word("t1_w0", 0, 32'hBAACABAA, 4, 1'b0);
    chk_word("t1_w1", 1, 32'h0000BCBB, 2, 1'b1);

    // ptr=3 then 4-lane end beat: full word, one stalled FLUSH cycle, remainder
    clear_got();
    send(32'h00C2C1C0, 3'd3, 1'b0);
    send(32'hD3D2D1D0, 3'd4, 1'b1);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    chk("t2_flush_ir", i_r, 1'b0);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    chk("t2_run_ir", i_r, 1'b1);
    idle(2);
    chk_word("t2_w0", 0, 32'hD0C2C1C0, 4, 1'b0);
    chk_word("t2_w1", 1, 32'h00D3D2D1, 3, 1'b1);

    // output backpressure for 5 cycles while input keeps offering
    clear_got();
    send(32'h44332211, 3'd4, 1'b0);
    repeat (5) begin
      cycle(1'b1, 32'h00006655, 3'd2, 1'b0, 1'b0);
      chk("t3_stall_ir", i_r, 1'b0);
      chk("t3_stall_d", o_d, 32'h44332211);
    end
    send(32'h00006655, 3'd2, 1'b0);
    send(32'h00008877, 3'd2, 1'b1);
    idle(3);
    chk_word("t3_w0", 0, 32'h44332211, 4, 1'b0);
    chk_word("t3_w1", 1, 32'h88776655, 4, 1'b1);

    // empty packet
    clear_got();
    send(32'hFFFFFFFF, 3'd0, 1'b1);
    idle(2);
    chk("t4_n", got_d.size(), 1);
    chk_word("t4_w0", 0, 32'h0, 0, 1'b1);

    // reset while FLUSH word is pending
    send(32'h00C2C1C0, 3'd3, 1'b0);
    send(32'hD3D2D1D0, 3'd4, 1'b1);
    cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    do_reset();
    send(32'h0000E1E0, 3'd2, 1'b1);
    idle(2);
    chk("t5_n", got_d.size(), 1);
    chk_word("t5_w0", 0, 32'h0000E1E0, 2, 1'b1);

`ifdef BASE_LANE_PACK_CNT_CHK_EN
    // illegal count: flagged, no lanes written, ptr unchanged
    clear_got();
    send(32'h000000AA, 3'd1, 1'b0);
    send(32'hFFFFFFFF, 3'd5, 1'b0);
    send(32'h000000BB, 3'd1, 1'b1);
    idle(2);
    chk("t6_err", o_err, 1'b1);
    chk_word("t6_w0", 0, 32'h0000BBAA, 2, 1'b1);
    do_reset();
`endif

    // randomized traffic with random output backpressure
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 4)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
